drum_cmd_scheduler: RTL

DRUM_CMD_SCHEDULER -- requirements
Module: drum_cmd_scheduler

---
 rtl/drum_cmd_scheduler.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/drum_cmd_scheduler.sv
// drum_cmd_scheduler: round-robin trigger arbiter, command FIFO and
// issue / ack / gap sequencer feeding the SPI slave.
module drum_cmd_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   trig_valid,
    input  logic [4*NUM_REQ-1:0] trig_code,
    input  logic                 command_sent,
    output logic                 drum_trigger_valid,
    output logic [3:0]           drum_code,
    output logic                 busy,
    output logic [2:0]           fifo_count,
    output logic [7:0]           drop_count,
    output logic [7:0]           timeout_count
);
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int DW = $clog2(NUM_REQ + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} state_t;

    state_t             state, state_nx;
    logic [NUM_REQ-1:0] pending;
    logic [3:0]         code_q [NUM_REQ];
    logic [RW-1:0]      rr, gnt_idx, idx;
    logic               push, pop, full;
    logic [3:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]      wp, rp;
    logic [TW-1:0]      timer;
    logic [GW-1:0]      gap_cnt;
    logic               gap_last, tout_inc;
    logic [NUM_REQ-1:0] drop_vec;
    logic [DW-1:0]      ndrop;
    logic [8:0]         drop_sum;

    assign drum_trigger_valid = (state == ISSUE);
    assign busy               = (state != IDLE);
    assign gap_last = (GAP_CYCLES <= 1) ||
                      (gap_cnt == GW'(GAP_CYCLES - 1));

    // Round-robin search starting at rr; nothing granted while full.
    always_comb begin
        push    = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        full    = (fifo_count == 3'(FIFO_DEPTH));
        for (int j = 0; j < NUM_REQ; j++) begin
            idx = rr + RW'(j);
            if (!full && !push && pending[idx]) begin
                push    = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        drop_vec = '0;
        ndrop    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (trig_valid[i]) begin
                if (trig_code[4*i+3])
                    drop_vec[i] = 1'b1;
                else if (pending[i] && !(push && gnt_idx == RW'(i)))
                    drop_vec[i] = 1'b1;
            end
            ndrop = ndrop + DW'(drop_vec[i]);
        end
        drop_sum = {1'b0, drop_count} + 9'(ndrop);
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        tout_inc = 1'b0;
        unique case (state)
            IDLE: begin
                if (fifo_count != 3'd0) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = WAIT_ACK;
            WAIT_ACK: begin
                if (command_sent || timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    tout_inc = !command_sent;
                    if (GAP_CYCLES == 0)
                        state_nx = IDLE;
                    else
                        state_nx = GAP;
                end
            end
            GAP: begin
                if (gap_last)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            pending       <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                code_q[i] <= '0;
            rr            <= '0;
            wp            <= '0;
            rp            <= '0;
            fifo_count    <= '0;
            drum_code     <= '0;
            timer         <= '0;
            gap_cnt       <= '0;
            drop_count    <= '0;
            timeout_count <= '0;
        end else begin
            state      <= state_nx;
            timer      <= (state == WAIT_ACK) ? timer + TW'(1) : '0;
            gap_cnt    <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            fifo_count <= fifo_count + 3'(push) - 3'(pop);
            if (push) begin
                mem[wp] <= code_q[gnt_idx];
                wp      <= wp + PW'(1);
                rr      <= gnt_idx + RW'(1);
            end
            if (pop) begin
                drum_code <= mem[rp];
                rp        <= rp + PW'(1);
            end
            // A fresh valid trigger re-arms even a requester granted now.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push && gnt_idx == RW'(i))
                    pending[i] <= 1'b0;
                if (trig_valid[i] && !trig_code[4*i+3]) begin
                    pending[i] <= 1'b1;
                    code_q[i]  <= trig_code[4*i +: 4];
                end
            end
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (tout_inc && timeout_count != 8'hFF)
                timeout_count <= timeout_count + 8'd1;
        end
    end
endmodule
